// File: rtl/addr_reg_file_p_pkg.sv
// Datapath package shared by the address register file and its function unit.
// Holds the 3-bit function codes applied to selected address registers.
package addr_reg_file_p_pkg;

    localparam int FUN_W = 3;

    typedef enum logic [FUN_W-1:0] {
        FS_DEC  = 3'b000,   // R - 1
        FS_INC  = 3'b001,   // R + 1
        FS_LOAD = 3'b010,   // R <- I
        FS_CLR  = 3'b011,   // R <- 0
        FS_LDLO = 3'b100,   // low half <- I low half
        FS_LDHI = 3'b101,   // high half <- I low half
        FS_ADD  = 3'b110,   // R + sign-extended I
        FS_HOLD = 3'b111    // no change
    } fun_e;

endpackage

// File: rtl/addr_fun_unit.sv
// Combinational per-register function unit.
// Ports:
//   cur    - current register value
//   fun    - function code (fun_e encoding)
//   din    - data / two's-complement offset input
//   nxt    - next register value (modulo 2^WIDTH)
//   carry  - upward wrap: INC from all-ones, or ADD of a non-negative offset with carry out
//   borrow - downward wrap: DEC from zero, or ADD of a negative offset with unsigned borrow
module addr_fun_unit
    import addr_reg_file_p_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [FUN_W-1:0] fun,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] nxt,
    output logic             carry,
    output logic             borrow
);

    localparam int H = WIDTH / 2;

    logic [WIDTH:0] sum;

    always_comb begin
        // Adding a negative offset subtracts its magnitude; the subtraction
        // borrowed exactly when the unsigned add produced no carry out.
        sum    = {1'b0, cur} + {1'b0, din};
        nxt    = cur;
        carry  = 1'b0;
        borrow = 1'b0;
        case (fun_e'(fun))
            FS_DEC: begin
                nxt    = cur - WIDTH'(1);
                borrow = (cur == '0);
            end
            FS_INC: begin
                nxt   = cur + WIDTH'(1);
                carry = &cur;
            end
            FS_LOAD: nxt = din;
            FS_CLR:  nxt = '0;
            FS_LDLO: nxt = {cur[WIDTH-1:H], din[H-1:0]};
            FS_LDHI: nxt = {din[H-1:0], cur[H-1:0]};
            FS_ADD: begin
                nxt    = sum[WIDTH-1:0];
                carry  = ~din[WIDTH-1] &  sum[WIDTH];
                borrow =  din[WIDTH-1] & ~sum[WIDTH];
            end
            FS_HOLD: nxt = cur;
        endcase
    end

endmodule

// File: rtl/addr_reg_file_p.sv
// Parametrised address register file (PC, AR, SP and spares).
// Ports:
//   clk, rst         - rising-edge clock, asynchronous active-low reset
//   E                - write enable for the whole file
//   FunSel           - function code applied to every selected register
//   RegSel           - one bit per register, 1 = update this register
//   OutCSel, OutDSel - read selects; out-of-range selects read 0
//   I                - data / offset input
//   FlagClr          - synchronous clear of the sticky stack flags
//   OutC, OutD       - combinational read ports
//   StkOvf, StkUnd   - sticky SP upward / downward wrap flags
module addr_reg_file_p
    import addr_reg_file_p_pkg::*;
#(
    parameter  int               WIDTH  = 16,
    parameter  int               NREGS  = 4,
    parameter  int               SP_IDX = 1,
    parameter  logic [WIDTH-1:0] PC_RST = '0,
    localparam int               SELW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             E,
    input  logic [2:0]       FunSel,
    input  logic [NREGS-1:0] RegSel,
    input  logic [SELW-1:0]  OutCSel,
    input  logic [SELW-1:0]  OutDSel,
    input  logic [WIDTH-1:0] I,
    input  logic             FlagClr,
    output logic [WIDTH-1:0] OutC,
    output logic [WIDTH-1:0] OutD,
    output logic             StkOvf,
    output logic             StkUnd
);

    localparam logic [NREGS-1:0] SP_MASK = NREGS'(1) << SP_IDX;

    logic [WIDTH-1:0] regs [NREGS];
    logic [NREGS-1:0] upd;
    logic [NREGS-1:0] carry_vec;
    logic [NREGS-1:0] borrow_vec;
    logic             ovf_set;
    logic             und_set;

    assign upd = E ? RegSel : '0;

    for (genvar k = 0; k < NREGS; k++) begin : g_slice
        localparam logic [WIDTH-1:0] RST_VAL = (k == 0) ? PC_RST : '0;

        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] nxt;

        addr_fun_unit #(.WIDTH(WIDTH)) u_fun (
            .cur    (q),
            .fun    (FunSel),
            .din    (I),
            .nxt    (nxt),
            .carry  (carry_vec[k]),
            .borrow (borrow_vec[k])
        );

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                q <= RST_VAL;
            end else if (upd[k]) begin
                q <= nxt;
            end
        end

        assign regs[k] = q;
    end

    // Only the SP slice may raise the flags, and only when it is being updated.
    assign ovf_set = |(carry_vec  & upd & SP_MASK);
    assign und_set = |(borrow_vec & upd & SP_MASK);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            StkOvf <= 1'b0;
            StkUnd <= 1'b0;
        end else begin
            // A new set condition overrides a simultaneous clear.
            StkOvf <= ovf_set | (StkOvf & ~FlagClr);
            StkUnd <= und_set | (StkUnd & ~FlagClr);
        end
    end

    always_comb begin
        OutC = '0;
        OutD = '0;
        for (int unsigned k = 0; k < NREGS; k++) begin
            if (OutCSel == SELW'(k)) OutC = regs[k];
            if (OutDSel == SELW'(k)) OutD = regs[k];
        end
    end

endmodule
